// File: rtl/input_logic_if.sv
// Word handshake from the sender plus the push side of the destination FIFOs.
interface input_logic_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
);
  logic                 data_in_req;
  logic [DATA_W-1:0]    data_in;
  logic                 data_in_ack;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_push;
  logic [DATA_W-1:0]    fifo_data;

  modport slave (
    input  data_in_req, data_in, fifo_full,
    output data_in_ack, fifo_push, fifo_data
  );

  modport master (
    output data_in_req, data_in, fifo_full,
    input  data_in_ack, fifo_push, fifo_data
  );
endinterface

// File: rtl/input_logic.sv
// Router input stage: decodes packet headers, steers words into the destination
// FIFO, drops packets for absent ports and keeps saturating status counters.
module input_logic #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3,
  parameter int DEST_W    = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input_logic_if.slave     bus,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  localparam int LEN_W = DATA_W - DEST_W;
  localparam int SLOTS = 2 ** DEST_W;

  typedef enum logic [1:0] {
    S_HDR     = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DROP    = 2'd2
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  rem_q;
  logic [DEST_W-1:0] dest_q;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic              drop_pulse_q;

  logic [DEST_W-1:0] hdr_dest;
  logic [LEN_W-1:0]  hdr_len;
  logic              hdr_valid;
  logic [SLOTS-1:0]  full_pad;
  logic              ack;
  logic              push_en;
  logic [DEST_W-1:0] push_dest;
  logic              xfer;

  assign hdr_dest  = bus.data_in[DEST_W-1:0];
  assign hdr_len   = bus.data_in[DATA_W-1:DEST_W];
  assign hdr_valid = (32'(hdr_dest) < NUM_PORTS);

  // Unused destination codes read as "not full" so indexing never leaves the vector.
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_full
      if (gi < NUM_PORTS) begin : g_real
        assign full_pad[gi] = bus.fifo_full[gi];
      end else begin : g_none
        assign full_pad[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    ack       = 1'b0;
    push_en   = 1'b0;
    push_dest = dest_q;
    case (state_q)
      S_HDR: begin
        ack       = hdr_valid ? !full_pad[hdr_dest] : 1'b1;
        push_en   = hdr_valid;
        push_dest = hdr_dest;
      end
      S_PAYLOAD: begin
        ack     = !full_pad[dest_q];
        push_en = 1'b1;
      end
      S_DROP: ack = 1'b1;
      default: ack = 1'b0;
    endcase
    if (rst) begin
      ack     = 1'b0;
      push_en = 1'b0;
    end
  end

  assign xfer            = bus.data_in_req && ack;
  assign bus.data_in_ack = ack;
  assign bus.fifo_data   = bus.data_in;

  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_push
      assign bus.fifo_push[gi] = xfer && push_en && (push_dest == DEST_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_HDR;
      rem_q        <= '0;
      dest_q       <= '0;
      pkt_cnt_q    <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (xfer) begin
        case (state_q)
          S_HDR: begin
            if (hdr_valid) begin
              dest_q <= hdr_dest;
              if (hdr_len == '0) begin
                if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
              end else begin
                rem_q   <= hdr_len;
                state_q <= S_PAYLOAD;
              end
            end else begin
              drop_pulse_q <= 1'b1;
              if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
              if (hdr_len != '0) begin
                rem_q   <= hdr_len;
                state_q <= S_DROP;
              end
            end
          end
          S_PAYLOAD: begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
              state_q <= S_HDR;
            end
          end
          S_DROP: begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= S_HDR;
          end
          default: state_q <= S_HDR;
        endcase
      end
    end
  end

  assign drop_pulse = drop_pulse_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign drop_cnt   = drop_cnt_q;
endmodule
